// File: rtl/regfile_write_arbiter.sv
// Shares the register file write port between WB (priority) and MC (anti-starvation), plus a zeroing sweep.
// Write lands one cycle after the valid/ready transfer; CLEAR holds off both requesters.
module regfile_write_arbiter #(
   parameter int DATA_W       = 32,
   parameter int ADDR_W       = 5,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wb_valid,
   input  logic [ADDR_W-1:0] wb_reg,
   input  logic [DATA_W-1:0] wb_data,
   output logic              wb_ready,
   input  logic              mc_valid,
   input  logic [ADDR_W-1:0] mc_reg,
   input  logic [DATA_W-1:0] mc_data,
   output logic              mc_ready,
   input  logic              clear_req,
   output logic              clear_busy,
   output logic              clear_done,
   output logic              rf_we,
   output logic [ADDR_W-1:0] rf_write_reg,
   output logic [DATA_W-1:0] rf_write_data
);

   typedef enum logic {ARB, CLEAR} state_e;

   localparam logic [3:0]        LIMIT    = 4'(STARVE_LIMIT);
   localparam logic [ADDR_W-1:0] LAST_REG = {ADDR_W{1'b1}};
   localparam logic [ADDR_W-1:0] ONE_REG  = ADDR_W'(1);

   state_e              state_q, state_d;
   logic [3:0]          starve_cnt_q, starve_cnt_d;
   logic                rf_we_q, rf_we_d;
   logic [ADDR_W-1:0]   rf_write_reg_q, rf_write_reg_d;
   logic [DATA_W-1:0]   rf_write_data_q, rf_write_data_d;
   logic                clear_busy_q, clear_busy_d;
   logic                clear_done_q, clear_done_d;
   logic                starved;
   logic                wb_xfer;
   logic                mc_xfer;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= ARB;
         starve_cnt_q    <= '0;
         rf_we_q         <= 1'b0;
         rf_write_reg_q  <= '0;
         rf_write_data_q <= '0;
         clear_busy_q    <= 1'b0;
         clear_done_q    <= 1'b0;
      end else begin
         state_q         <= state_d;
         starve_cnt_q    <= starve_cnt_d;
         rf_we_q         <= rf_we_d;
         rf_write_reg_q  <= rf_write_reg_d;
         rf_write_data_q <= rf_write_data_d;
         clear_busy_q    <= clear_busy_d;
         clear_done_q    <= clear_done_d;
      end
   end

   // In CLEAR the write index register doubles as the sweep pointer.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ARB:     if (clear_req) state_d = CLEAR;
         CLEAR:   if (rf_write_reg_q == LAST_REG) state_d = ARB;
         default: state_d = ARB;
      endcase
   end

   always_comb begin
      starved  = (starve_cnt_q == LIMIT);
      mc_ready = 1'b0;
      wb_ready = 1'b0;
      if (state_q == ARB && !clear_req) begin
         mc_ready = mc_valid && (starved || !wb_valid);
         wb_ready = wb_valid && !mc_ready;
      end
      wb_xfer = wb_valid && wb_ready;
      mc_xfer = mc_valid && mc_ready;

      starve_cnt_d = starve_cnt_q;
      if (mc_xfer)
         starve_cnt_d = '0;
      else if (state_q == ARB && mc_valid && !starved)
         starve_cnt_d = starve_cnt_q + 4'd1;

      rf_we_d         = 1'b0;
      rf_write_reg_d  = rf_write_reg_q;
      rf_write_data_d = rf_write_data_q;
      clear_busy_d    = 1'b0;
      clear_done_d    = 1'b0;
      if (state_q == CLEAR) begin
         if (rf_write_reg_q != LAST_REG) begin
            rf_we_d         = 1'b1;
            rf_write_reg_d  = rf_write_reg_q + ONE_REG;
            rf_write_data_d = '0;
            clear_busy_d    = 1'b1;
         end else begin
            clear_done_d = 1'b1;
         end
      end else if (clear_req) begin
         rf_we_d         = 1'b1;
         rf_write_reg_d  = ONE_REG;
         rf_write_data_d = '0;
         clear_busy_d    = 1'b1;
      end else if (wb_xfer) begin
         // Register 0 is hardwired: accept the request but suppress the write.
         rf_we_d         = (wb_reg != '0);
         rf_write_reg_d  = wb_reg;
         rf_write_data_d = wb_data;
      end else if (mc_xfer) begin
         rf_we_d         = (mc_reg != '0);
         rf_write_reg_d  = mc_reg;
         rf_write_data_d = mc_data;
      end
   end

   assign rf_we         = rf_we_q;
   assign rf_write_reg  = rf_write_reg_q;
   assign rf_write_data = rf_write_data_q;
   assign clear_busy    = clear_busy_q;
   assign clear_done    = clear_done_q;

endmodule
